// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl
//   SHAKE sponge controller wrapped around an external Keccak-f[1600] core.
//   Absorbs a 64-bit little-endian lane stream into the rate portion of the
//   state, applies SHAKE padding (DOMAIN byte + final 0x80), launches the
//   permutation, then squeezes an unbounded lane stream, re-permuting each
//   time the rate is exhausted, until i_clear.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_clear              synchronous abort: zero state, back to absorb
//   in_valid/in_ready    message lane handshake
//   in_data/in_last      message lane and end-of-message marker
//   in_bytes             valid bytes in the final lane (0..8, >8 means 8)
//   out_valid/out_ready  squeeze lane handshake
//   out_data             squeeze lane
//   perm_start           one-cycle launch pulse to the permutation core
//   perm_data            state presented to the core
//   perm_valid           one-cycle result strobe from the core
//   perm_result          permuted state
//   perm_busy            core is running; no launch is issued while high
module keccak_sponge_ctrl #(
  parameter int unsigned RATE_LANES  = 21,
  parameter logic [7:0]  DOMAIN      = 8'h1F,
  parameter int unsigned STATE_WIDTH = 1600
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_data,
  input  logic                   in_last,
  input  logic [3:0]             in_bytes,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic                   perm_start,
  output logic [STATE_WIDTH-1:0] perm_data,
  input  logic                   perm_valid,
  input  logic [STATE_WIDTH-1:0] perm_result,
  input  logic                   perm_busy
);

  localparam logic [4:0]  LAST_LANE    = 5'(RATE_LANES - 1);
  localparam int unsigned END_BYTE_LSB = (RATE_LANES - 1) * 64 + 56;

  typedef enum logic [2:0] {
    S_ABSORB,
    S_PAD,
    S_WAIT_A,
    S_WAIT_P,
    S_WAIT_S,
    S_SQUEEZE
  } state_e;

  state_e                 fsm;
  logic [STATE_WIDTH-1:0] state;
  logic [4:0]             lane_idx;
  logic [4:0]             pad_lane;
  logic [2:0]             pad_byte;
  logic                   pad_wrap;
  logic                   start_pend;

  logic [3:0]             eff_bytes;
  logic [63:0]            byte_mask;
  logic [4:0]             next_idx;
  logic [10:0]            lane_base;
  logic [10:0]            next_base;
  logic [10:0]            pad_base;
  logic [STATE_WIDTH-1:0] absorb_vec;
  logic [STATE_WIDTH-1:0] pad_vec;

  assign perm_data = state;

  always_comb begin
    eff_bytes = (!in_last || (in_bytes > 4'd8)) ? 4'd8 : in_bytes;
    byte_mask = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      byte_mask[8*k +: 8] = (4'(k) < eff_bytes) ? 8'hFF : 8'h00;
    end
    next_idx  = lane_idx + 5'd1;
    lane_base = {lane_idx, 6'b0};
    next_base = {next_idx, 6'b0};
    pad_base  = {pad_lane, pad_byte, 3'b0};

    absorb_vec = '0;
    absorb_vec[lane_base +: 64] = in_data & byte_mask;

    // XOR composition makes DOMAIN and 0x80 merge into one byte when the
    // pad position is the last byte of the rate.
    pad_vec = '0;
    pad_vec[pad_base +: 8]     = DOMAIN;
    pad_vec[END_BYTE_LSB +: 8] = pad_vec[END_BYTE_LSB +: 8] ^ 8'h80;
  end

  // Launches are deferred via start_pend while the core is still busy (it
  // can be finishing a permutation that an i_clear abandoned). A result is
  // accepted only once our own launch has gone out, so stale strobes from an
  // abandoned permutation never reach the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= S_ABSORB;
      state      <= '0;
      lane_idx   <= '0;
      pad_lane   <= '0;
      pad_byte   <= '0;
      pad_wrap   <= 1'b0;
      start_pend <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      perm_start <= 1'b0;
    end else begin
      perm_start <= 1'b0;
      if (i_clear) begin
        fsm        <= S_ABSORB;
        state      <= '0;
        lane_idx   <= '0;
        pad_lane   <= '0;
        pad_byte   <= '0;
        pad_wrap   <= 1'b0;
        start_pend <= 1'b0;
        in_ready   <= 1'b1;
        out_valid  <= 1'b0;
        out_data   <= '0;
      end else begin
        case (fsm)
          S_ABSORB: begin
            if (in_valid && in_ready) begin
              state <= state ^ absorb_vec;
              if (in_last) begin
                in_ready <= 1'b0;
                fsm      <= S_PAD;
                if (eff_bytes != 4'd8) begin
                  pad_lane <= lane_idx;
                  pad_byte <= eff_bytes[2:0];
                  pad_wrap <= 1'b0;
                end else if (lane_idx == LAST_LANE) begin
                  // Full last lane closes the block: permute it first, then
                  // a padding-only block starts at lane 0 byte 0.
                  pad_lane <= '0;
                  pad_byte <= '0;
                  pad_wrap <= 1'b1;
                end else begin
                  pad_lane <= next_idx;
                  pad_byte <= '0;
                  pad_wrap <= 1'b0;
                end
              end else if (lane_idx == LAST_LANE) begin
                lane_idx   <= '0;
                in_ready   <= 1'b0;
                perm_start <= !perm_busy;
                start_pend <= perm_busy;
                fsm        <= S_WAIT_A;
              end else begin
                lane_idx <= next_idx;
              end
            end else begin
              in_ready <= 1'b1;
            end
          end

          S_PAD: begin
            perm_start <= !perm_busy;
            start_pend <= perm_busy;
            if (pad_wrap) begin
              pad_wrap <= 1'b0;
              fsm      <= S_WAIT_P;
            end else begin
              state <= state ^ pad_vec;
              fsm   <= S_WAIT_S;
            end
          end

          S_WAIT_A, S_WAIT_P, S_WAIT_S: begin
            if (start_pend) begin
              if (!perm_busy) begin
                perm_start <= 1'b1;
                start_pend <= 1'b0;
              end
            end else if (!perm_start && perm_valid) begin
              state <= perm_result;
              case (fsm)
                S_WAIT_A: begin
                  fsm      <= S_ABSORB;
                  in_ready <= 1'b1;
                end
                S_WAIT_P: begin
                  fsm <= S_PAD;
                end
                default: begin
                  fsm       <= S_SQUEEZE;
                  lane_idx  <= '0;
                  out_valid <= 1'b1;
                  out_data  <= perm_result[63:0];
                end
              endcase
            end
          end

          S_SQUEEZE: begin
            if (out_valid && out_ready) begin
              if (lane_idx == LAST_LANE) begin
                lane_idx   <= '0;
                out_valid  <= 1'b0;
                perm_start <= !perm_busy;
                start_pend <= perm_busy;
                fsm        <= S_WAIT_S;
              end else begin
                lane_idx <= next_idx;
                out_data <= state[next_base +: 64];
              end
            end
          end

          default: begin
            fsm <= S_ABSORB;
          end
        endcase
      end
    end
  end

endmodule
